lcd_busy_reader: RTL and testbench
==================================

LCD_BUSY_READER -- requirements
Module: lcd_busy_reader

Interface
REQ-001 SHALL have parameter T_AS, default 3, meaning address-setup cycles with RS/RW valid before E rises (62.5 ns at 48 MHz).
REQ-002 SHALL have parameter T_EH, default 12, meaning E-high cycles per read strobe (250 ns).
REQ-003 SHALL have parameter T_EL, default 12, meaning E-low cycles between strobes (250 ns).
REQ-004 SHALL have parameter MAX_POLLS, default 4800, meaning strobe limit before timeout (about 2.4 ms).
REQ-005 SHALL have port CLK, input, 1 bit: the single system clock, 48 MHz.
REQ-006 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to poll the LCD busy flag.
REQ-008 SHALL have port LCD_DB_IN, input, 8 bits: LCD data bus as read back from the pads.
REQ-009 SHALL have port LCD_RS, output, 1 bit: register select; always 0 (instruction register).
REQ-010 SHALL have port LCD_RW, output, 1 bit: 1 = read.
REQ-011 SHALL have port LCD_E, output, 1 bit: LCD enable strobe.
REQ-012 SHALL have port bus_req, output, 1 bit: 1 while the block owns RS/RW/E and the bus must be tristated by the top level.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port timeout, output, 1 bit: qualifies done; 1 = busy flag never cleared.
REQ-015 SHALL have port addr_cnt, output, 7 bits: LCD address counter (DB6..DB0) from the last strobe.

Function
REQ-016 SHALL implement states IDLE, SETUP, E_HIGH, E_LOW, DONE.
REQ-017 IDLE: LCD_E=0, LCD_RW=0, bus_req=0; on start=1, go to SETUP, clear the poll counter, and clear timeout.
REQ-018 SETUP: LCD_RW=1, LCD_E=0, bus_req=1; hold exactly T_AS cycles, then go to E_HIGH.
REQ-019 E_HIGH: LCD_E=1 for exactly T_EH cycles; on the last cycle register LCD_DB_IN[7] as bf and LCD_DB_IN[6:0] into addr_cnt, and increment the poll counter.
REQ-020 E_LOW: LCD_E=0 for exactly T_EL cycles; on the last cycle, if bf=0 go to DONE with timeout=0.
REQ-021 On the last E_LOW cycle, if bf=1 and the poll count equals MAX_POLLS, go to DONE with timeout=1.
REQ-022 On the last E_LOW cycle, if bf=1 and the poll count is below MAX_POLLS, go to E_HIGH, keeping RW=1 with no new SETUP.
REQ-023 DONE: done=1 for exactly one cycle, LCD_RW=1, E=0; next state IDLE.
REQ-024 Latency for a not-busy LCD: start in cycle 0 -> done in cycle T_AS+T_EH+T_EL+1 (28 with defaults).
REQ-025 start while not in IDLE SHALL be ignored; start coincident with DONE SHALL be ignored.
REQ-026 LCD_RW SHALL NOT fall while LCD_E=1; LCD_E SHALL rise only from SETUP or E_LOW.
REQ-027 The timing counter SHALL be 8 bits and the poll counter 16 bits; a parameter value not representable in its counter is illegal and flagged by an elaboration-time check.
REQ-028 addr_cnt and timeout SHALL hold their values until the next start is accepted.

Reset
REQ-029 RST_N=0 SHALL asynchronously force state IDLE, LCD_E=0, LCD_RW=0, LCD_RS=0, bus_req=0, done=0, timeout=0, addr_cnt=0, and all counters to 0.
REQ-030 Reset asserted mid-strobe SHALL drop LCD_E in the same clock period without waiting for a clock edge.
REQ-031 Release of RST_N SHALL be synchronised before use; the first start is accepted no earlier than 2 cycles after release.

Structure
REQ-032 Timing constants (48 MHz cycle counts: T_AS, T_EH, T_EL, MAX_POLLS, and the existing 42 us / 1640 us write delays) SHALL live in shared package lcd_pkg.
REQ-033 The state encoding SHALL live in shared package lcd_pkg.
REQ-034 Cycle counting SHALL be done by one sub-module, lcd_cycle_timer (load value, run, expire pulse), instantiated once.
REQ-035 State transitions SHALL use the lcd_cycle_timer expire pulse only.

Verification
REQ-036 Scenario, not busy: LCD_DB_IN=8'h05 constant, start pulse -> exactly one E pulse of 12 cycles, done at cycle 28, addr_cnt=7'h05, timeout=0.
REQ-037 Scenario, busy then clear: LCD_DB_IN=8'h8A for 3 strobes, then 8'h0B -> 4 E pulses spaced 24 cycles apart, done with addr_cnt=7'h0B, timeout=0.
REQ-038 Scenario, stuck busy: LCD_DB_IN=8'hFF, MAX_POLLS=4 -> exactly 4 E pulses, done with timeout=1, addr_cnt=7'h7F.
REQ-039 Scenario, ignored start: second start issued 10 cycles after the first -> no restart, single done, poll count unaffected.
REQ-040 Scenario, mid-strobe reset: RST_N low during cycle 6 of E_HIGH -> LCD_E=0 and LCD_RW=0 before the next edge, no done; a new start after release completes normally.
REQ-041 Scenario, protocol checker: assertions across all scenarios show RS=0 always, no RW change while E=1, and E-high/E-low widths never below T_EH/T_EL.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD interface package: 48 MHz cycle-count timing constants,
// counter widths and the controller state encoding.
package lcd_pkg;

   localparam int T_AS_CYC      = 3;      // 62.5 ns address setup
   localparam int T_EH_CYC      = 12;     // 250 ns E high
   localparam int T_EL_CYC      = 12;     // 250 ns E low
   localparam int MAX_POLLS_CYC = 4800;   // roughly 2.4 ms of busy polling
   localparam int T_WR_CYC      = 2016;   // 42 us write delay
   localparam int T_WR_LONG_CYC = 78720;  // 1640 us clear/home delay

   localparam int TMR_W       = 8;
   localparam int POLL_W      = 16;
   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      E_HIGH = 3'd2,
      E_LOW  = 3'd3,
      DONE   = 3'd4
   } lcd_state_t;

   // True when a cycle count is non-zero and representable in a w-bit counter.
   function automatic logic fits_counter(input int value, input int w);
      return (value >= 1) && (value < (1 << w));
   endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Down-counting cycle timer: load N, then expire pulses on the Nth cycle
// after the load while run is high.
module lcd_cycle_timer
   import lcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   input  logic             run,
   output logic             expire
);

   logic [TMR_W-1:0] cnt_reg;
   logic             active_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg    <= '0;
         active_reg <= 1'b0;
      end else if (load) begin
         cnt_reg    <= load_val - TMR_W'(1);
         active_reg <= 1'b1;
      end else if (run && active_reg) begin
         if (cnt_reg == '0)
            active_reg <= 1'b0;
         else
            cnt_reg <= cnt_reg - TMR_W'(1);
      end
   end

   assign expire = run && active_reg && (cnt_reg == '0);

endmodule

// File: rtl/lcd_busy_reader.sv
// Reads the HD44780-style busy flag and address counter by strobing E with
// RS=0/RW=1 until the busy flag clears or the poll limit is reached.
module lcd_busy_reader
   import lcd_pkg::*;
#(
   parameter int T_AS      = T_AS_CYC,
   parameter int T_EH      = T_EH_CYC,
   parameter int T_EL      = T_EL_CYC,
   parameter int MAX_POLLS = MAX_POLLS_CYC
)(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       start,
   input  logic [7:0] LCD_DB_IN,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_E,
   output logic       bus_req,
   output logic       done,
   output logic       timeout,
   output logic [6:0] addr_cnt
);

   if (!fits_counter(T_AS, TMR_W) || !fits_counter(T_EH, TMR_W) ||
       !fits_counter(T_EL, TMR_W) || !fits_counter(MAX_POLLS, POLL_W)) begin : g_bad_param
      $error("lcd_busy_reader: timing parameter does not fit its counter");
   end

   // Assertion is immediate; release is delayed through the synchroniser.
   logic [SYNC_STAGES-1:0] rst_sync_reg;
   logic                   rst_n_int;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         rst_sync_reg <= '0;
      else
         rst_sync_reg <= {rst_sync_reg[SYNC_STAGES-2:0], 1'b1};
   end

   assign rst_n_int = rst_sync_reg[SYNC_STAGES-1];

   lcd_state_t        state_reg, state_next;
   logic [POLL_W-1:0] poll_cnt_reg, poll_cnt_next;
   logic              bf_reg, bf_next;
   logic [6:0]        addr_cnt_reg, addr_cnt_next;
   logic              timeout_reg, timeout_next;
   logic              e_reg, rw_reg, bus_req_reg, done_reg;
   logic              tmr_load, tmr_run, tmr_expire;
   logic [TMR_W-1:0]  tmr_val;

   lcd_cycle_timer u_timer (
      .clk      (CLK),
      .rst_n    (rst_n_int),
      .load     (tmr_load),
      .load_val (tmr_val),
      .run      (tmr_run),
      .expire   (tmr_expire)
   );

   assign tmr_run = (state_reg != IDLE);

   always_comb begin
      state_next    = state_reg;
      poll_cnt_next = poll_cnt_reg;
      bf_next       = bf_reg;
      addr_cnt_next = addr_cnt_reg;
      timeout_next  = timeout_reg;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      case (state_reg)
         IDLE: if (start) begin
            state_next    = SETUP;
            poll_cnt_next = '0;
            timeout_next  = 1'b0;
            tmr_load      = 1'b1;
            tmr_val       = TMR_W'(T_AS);
         end
         SETUP: if (tmr_expire) begin
            state_next = E_HIGH;
            tmr_load   = 1'b1;
            tmr_val    = TMR_W'(T_EH);
         end
         E_HIGH: if (tmr_expire) begin
            state_next    = E_LOW;
            bf_next       = LCD_DB_IN[7];
            addr_cnt_next = LCD_DB_IN[6:0];
            poll_cnt_next = poll_cnt_reg + POLL_W'(1);
            tmr_load      = 1'b1;
            tmr_val       = TMR_W'(T_EL);
         end
         E_LOW: if (tmr_expire) begin
            tmr_load = 1'b1;
            if (!bf_reg || poll_cnt_reg >= POLL_W'(MAX_POLLS)) begin
               // DONE lasts one timer cycle so its exit also rides on expire.
               state_next   = DONE;
               timeout_next = bf_reg;
               tmr_val      = TMR_W'(1);
            end else begin
               state_next = E_HIGH;
               tmr_val    = TMR_W'(T_EH);
            end
         end
         DONE: if (tmr_expire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the LCD pins never glitch.
   always_ff @(posedge CLK or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_reg    <= IDLE;
         poll_cnt_reg <= '0;
         bf_reg       <= 1'b0;
         addr_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
         e_reg        <= 1'b0;
         rw_reg       <= 1'b0;
         bus_req_reg  <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         poll_cnt_reg <= poll_cnt_next;
         bf_reg       <= bf_next;
         addr_cnt_reg <= addr_cnt_next;
         timeout_reg  <= timeout_next;
         e_reg        <= (state_next == E_HIGH);
         rw_reg       <= (state_next != IDLE);
         bus_req_reg  <= (state_next != IDLE);
         done_reg     <= (state_next == DONE);
      end
   end

   assign LCD_RS   = 1'b0;
   assign LCD_RW   = rw_reg;
   assign LCD_E    = e_reg;
   assign bus_req  = bus_req_reg;
   assign done     = done_reg;
   assign timeout  = timeout_reg;
   assign addr_cnt = addr_cnt_reg;

endmodule

// File: tb/tb_lcd_busy_reader.sv
// Self-checking bench for lcd_busy_reader: directed scenarios plus randomized
// busy sequences compared against a strobe-count/latency reference model.
module tb_lcd_busy_reader;
   import lcd_pkg::*;

   localparam int MP     = 4;
   localparam int PERIOD = T_EH_CYC + T_EL_CYC;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] db = 8'h00;
   logic       lcd_rs, lcd_rw, lcd_e, bus_req, done, timeout;
   logic [6:0] addr_cnt;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] db_q[$];

   always #5 clk = ~clk;

   lcd_busy_reader #(
      .T_AS      (T_AS_CYC),
      .T_EH      (T_EH_CYC),
      .T_EL      (T_EL_CYC),
      .MAX_POLLS (MP)
   ) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .start     (start),
      .LCD_DB_IN (db),
      .LCD_RS    (lcd_rs),
      .LCD_RW    (lcd_rw),
      .LCD_E     (lcd_e),
      .bus_req   (bus_req),
      .done      (done),
      .timeout   (timeout),
      .addr_cnt  (addr_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Protocol monitor: RS low, RW steady while E high, E widths.
   int   hi_len = 0, lo_len = 0;
   logic m_prev_e = 1'b0, m_prev_rw = 1'b0, rw_moved = 1'b0, seen_fall = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hi_len = 0; lo_len = 0; m_prev_e = 1'b0; rw_moved = 1'b0; seen_fall = 1'b0;
      end else begin
         if (lcd_e) begin
            if (!m_prev_e) begin
               check_eq("rs_zero", 32'(lcd_rs), 32'd0);
               if (seen_fall) check_eq("e_low_w", 32'(lo_len >= T_EL_CYC), 32'd1);
               hi_len = 0;
               rw_moved = 1'b0;
            end else if (lcd_rw !== m_prev_rw) begin
               rw_moved = 1'b1;
            end
            hi_len++;
         end else begin
            if (m_prev_e) begin
               check_eq("e_high_w", 32'(hi_len), 32'(T_EH_CYC));
               check_eq("rw_stable", 32'(rw_moved), 32'd0);
               seen_fall = 1'b1;
               lo_len = 0;
            end
            lo_len++;
         end
         m_prev_e  = lcd_e;
         m_prev_rw = lcd_rw;
      end
   end

   // One poll transaction; db_q holds the bus value for each successive strobe.
   task automatic run_txn(input int id, input bit extra_start);
      int         exp_n = MP, exp_lat;
      bit         exp_to = 1'b1;
      logic [6:0] exp_addr;
      logic [7:0] cur;
      int         pulses = 0, done_c = -1, done_cnt = 0, last_rise = 0, idx = 0;
      logic       pe = 1'b0;

      for (int i = 0; i < MP; i++) begin
         cur = db_q[i];
         if (!cur[7]) begin exp_n = i + 1; exp_to = 1'b0; break; end
      end
      cur      = db_q[exp_n-1];
      exp_addr = cur[6:0];
      exp_lat  = T_AS_CYC + exp_n * PERIOD + 1;

      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         start = extra_start && (c == 10);
         if (lcd_e && !pe) begin
            if (pulses > 0) check_eq("pulse_gap", 32'(c - last_rise), 32'(PERIOD));
            last_rise = c;
            db = db_q[(idx < MP) ? idx : MP-1];
            idx++;
            pulses++;
         end
         pe = lcd_e;
         if (done) begin
            done_cnt++;
            if (done_c < 0) done_c = c;
         end
         if (done_c >= 0 && c >= done_c + 5) break;
      end
      start = 1'b0;

      check_eq("done_lat", 32'(done_c), 32'(exp_lat));
      check_eq("done_once", 32'(done_cnt), 32'd1);
      check_eq("pulses", 32'(pulses), 32'(exp_n));
      check_eq("timeout", 32'(timeout), 32'(exp_to));
      check_eq("addr_cnt", 32'(addr_cnt), 32'(exp_addr));
      check_eq("idle_bus", 32'(bus_req), 32'd0);
      $display("txn %0d strobes=%0d timeout=%0b addr=%02h done_at=%0d extra_start=%0b",
               id, pulses, timeout, addr_cnt, done_c, extra_start);
   endtask

   task automatic load_q(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
      db_q.delete();
      db_q.push_back(a); db_q.push_back(b); db_q.push_back(c); db_q.push_back(d);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   k;
      logic seen_done;

      repeat (3) @(negedge clk);
      check_eq("rst_e", 32'(lcd_e), 32'd0);
      check_eq("rst_rw", 32'(lcd_rw), 32'd0);
      check_eq("rst_rs", 32'(lcd_rs), 32'd0);
      check_eq("rst_bus", 32'(bus_req), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_to", 32'(timeout), 32'd0);
      check_eq("rst_addr", 32'(addr_cnt), 32'd0);

      // Start during the two synchroniser cycles after release is ignored.
      rst_n = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      check_eq("early_start", 32'(bus_req), 32'd0);
      @(negedge clk);
      check_eq("early_start2", 32'(bus_req), 32'd0);

      load_q(8'h05, 8'h05, 8'h05, 8'h05);
      run_txn(0, 1'b0);
      load_q(8'h8A, 8'h8A, 8'h8A, 8'h0B);
      run_txn(1, 1'b0);
      load_q(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      run_txn(2, 1'b0);
      load_q(8'h05, 8'h05, 8'h05, 8'h05);
      run_txn(3, 1'b1);

      // Reset in the sixth E-high cycle of a busy poll.
      load_q(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      db = 8'hFF;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && !lcd_e; i++) @(negedge clk);
      check_eq("e_rise_seen", 32'(lcd_e), 32'd1);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("async_e", 32'(lcd_e), 32'd0);
      check_eq("async_rw", 32'(lcd_rw), 32'd0);
      check_eq("async_bus", 32'(bus_req), 32'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen_done = seen_done | done;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seen_done = seen_done | done;
      end
      check_eq("no_done_rst", 32'(seen_done), 32'd0);
      $display("txn mid-strobe reset applied");
      load_q(8'h12, 8'h12, 8'h12, 8'h12);
      run_txn(4, 1'b0);

      for (int t = 5; t < 21; t++) begin
         k = int'($urandom_range(0, 5));
         db_q.delete();
         for (int i = 0; i < MP; i++) db_q.push_back({(i < k), 7'($urandom)});
         run_txn(t, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
